// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB result type and core sizing constants.
// Also used by the issue table for tag wakeup.
package cdb_arbiter_pkg;

    localparam int unsigned NUM_FU       = 4;
    localparam int unsigned NUM_CDB      = 2;
    localparam int unsigned NUM_PHYS_REG = 32;
    localparam int unsigned WORD_SIZE    = 16;
    localparam int unsigned DEST_W       = $clog2(NUM_PHYS_REG);

    typedef struct packed {
        logic [DEST_W-1:0]    dest;
        logic [WORD_SIZE-1:0] data;
    } CDB_t;

    // Index width that stays legal for a single requester.
    function automatic int unsigned ptr_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cdb_arbiter_rr_multi_grant.sv
// Combinational round-robin arbiter that issues up to NUM_CDB_P grants per cycle.
// Each slot stage rotates the remaining requests to rr_ptr and takes the lowest one.
module rr_multi_grant #(
    parameter int unsigned NUM_REQ_P = 4,
    parameter int unsigned NUM_CDB_P = 2,
    parameter int unsigned PTR_W     = 2
) (
    input  logic [NUM_REQ_P-1:0]                req_i,
    input  logic [PTR_W-1:0]                    rr_ptr_i,
    output logic [NUM_REQ_P-1:0]                grant_o,
    output logic [NUM_CDB_P-1:0][PTR_W-1:0]     slot_idx_o,
    output logic [NUM_CDB_P-1:0]                slot_v_o,
    output logic [PTR_W-1:0]                    rr_ptr_next_o
);

    // Sums never exceed 2*NUM_REQ_P-2, so one conditional subtract wraps them.
    function automatic logic [PTR_W-1:0] wrap(input int unsigned v);
        int unsigned w;
        w = (v >= NUM_REQ_P) ? v - NUM_REQ_P : v;
        return PTR_W'(w);
    endfunction

    logic [NUM_REQ_P-1:0] remaining;
    logic [NUM_REQ_P-1:0] rotated;
    logic                 found;
    logic [PTR_W-1:0]     pos;
    logic [PTR_W-1:0]     abs_idx;

    always_comb begin
        remaining     = req_i;
        rotated       = '0;
        found         = 1'b0;
        pos           = '0;
        abs_idx       = '0;
        grant_o       = '0;
        slot_idx_o    = '0;
        slot_v_o      = '0;
        rr_ptr_next_o = rr_ptr_i;

        for (int unsigned k = 0; k < NUM_CDB_P; k++) begin
            for (int unsigned i = 0; i < NUM_REQ_P; i++) begin
                rotated[i] = remaining[wrap(i + 32'(rr_ptr_i))];
            end

            found = 1'b0;
            pos   = '0;
            for (int unsigned i = 0; i < NUM_REQ_P; i++) begin
                if (!found && rotated[i]) begin
                    found = 1'b1;
                    pos   = PTR_W'(i);
                end
            end

            if (found) begin
                abs_idx             = wrap(32'(pos) + 32'(rr_ptr_i));
                remaining[abs_idx]  = 1'b0;
                grant_o[abs_idx]    = 1'b1;
                slot_v_o[k]         = 1'b1;
                slot_idx_o[k]       = abs_idx;
                // Later slots overwrite this, leaving it one past the last grant.
                rr_ptr_next_o       = wrap(32'(abs_idx) + 1);
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one-entry holding buffer per FU, round-robin
// multi-slot grant, registered CDB outputs.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ_P   = NUM_FU,
    parameter int unsigned NUM_CDB_P   = NUM_CDB,
    parameter int unsigned WORD_SIZE_P = WORD_SIZE
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic                       flush_i,
    input  logic [NUM_REQ_P-1:0]       fu_v_i,
    input  CDB_t [NUM_REQ_P-1:0]       fu_result_i,
    output logic [NUM_REQ_P-1:0]       fu_ready_o,
    output logic [NUM_CDB_P-1:0]       cdb_v_o,
    output CDB_t [NUM_CDB_P-1:0]       cdb_o
);

    localparam int unsigned PTR_W = ptr_width(NUM_REQ_P);

    // Data width is fixed by the shared CDB_t type.
    if (WORD_SIZE_P != WORD_SIZE) begin : g_bad_word_size
        $error("cdb_arbiter: WORD_SIZE_P must equal the package WORD_SIZE");
    end
    if (NUM_CDB_P < 1 || NUM_CDB_P > NUM_REQ_P) begin : g_bad_num_cdb
        $error("cdb_arbiter: NUM_CDB_P must be in 1..NUM_REQ_P");
    end

    CDB_t [NUM_REQ_P-1:0]            hold_q, hold_d;
    logic [NUM_REQ_P-1:0]            hold_v_q, hold_v_d;
    CDB_t [NUM_CDB_P-1:0]            cdb_q, cdb_d;
    logic [NUM_CDB_P-1:0]            cdb_v_q, cdb_v_d;
    logic [PTR_W-1:0]                rr_ptr_q, rr_ptr_d;

    logic [NUM_REQ_P-1:0]            grant;
    logic [NUM_CDB_P-1:0][PTR_W-1:0] slot_idx;
    logic [NUM_CDB_P-1:0]            slot_v;
    logic [PTR_W-1:0]                rr_ptr_next;
    logic [NUM_REQ_P-1:0]            ready;
    logic [NUM_REQ_P-1:0]            capture;

    rr_multi_grant #(
        .NUM_REQ_P (NUM_REQ_P),
        .NUM_CDB_P (NUM_CDB_P),
        .PTR_W     (PTR_W)
    ) u_rr_multi_grant (
        .req_i         (hold_v_q),
        .rr_ptr_i      (rr_ptr_q),
        .grant_o       (grant),
        .slot_idx_o    (slot_idx),
        .slot_v_o      (slot_v),
        .rr_ptr_next_o (rr_ptr_next)
    );

    always_comb begin
        // A granted entry frees its buffer this cycle, so the FU can stream.
        ready    = {NUM_REQ_P{~flush_i}} & (~hold_v_q | grant);
        capture  = fu_v_i & ready;

        hold_d   = hold_q;
        hold_v_d = hold_v_q & ~grant;
        for (int unsigned r = 0; r < NUM_REQ_P; r++) begin
            if (capture[r]) begin
                hold_d[r]   = fu_result_i[r];
                hold_v_d[r] = 1'b1;
            end
        end
        if (flush_i) begin
            hold_v_d = '0;
        end

        cdb_d   = cdb_q;
        cdb_v_d = '0;
        for (int unsigned k = 0; k < NUM_CDB_P; k++) begin
            if (slot_v[k] && !flush_i) begin
                cdb_v_d[k] = 1'b1;
                cdb_d[k]   = hold_q[slot_idx[k]];
            end
        end

        rr_ptr_d = flush_i ? rr_ptr_q : rr_ptr_next;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            hold_q   <= '0;
            hold_v_q <= '0;
            cdb_q    <= '0;
            cdb_v_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            hold_q   <= hold_d;
            hold_v_q <= hold_v_d;
            cdb_q    <= cdb_d;
            cdb_v_q  <= cdb_v_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign fu_ready_o = ready;
    assign cdb_v_o    = cdb_v_q;
    assign cdb_o      = cdb_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter (4 FUs, 2 CDB slots) with a queue-level
// reference model checked every cycle plus hand-computed expectations.
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    localparam int N = 4;
    localparam int C = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush;
    logic [N-1:0]     fu_v;
    CDB_t [N-1:0]     fu_res;
    logic [N-1:0]     fu_ready;
    logic [C-1:0]     cdb_v;
    CDB_t [C-1:0]     cdb;

    int checks = 0;
    int errors = 0;

    logic [N-1:0] acc;
    int           seq [N];
    int           sat_cnt [N];
    int           toggles;
    logic         prev_rdy0;
    int           stream_d;

    // Reference model state
    logic [N-1:0] m_hv = '0;
    CDB_t         m_hd [N];
    int           m_ptr = 0;
    logic [C-1:0] m_cv = '0;
    CDB_t         m_cd [C];
    int           m_cnt;
    int           m_sl [C];
    int           m_idx;
    logic [N-1:0] m_g;
    logic [N-1:0] m_rdy;

    cdb_arbiter #(
        .NUM_REQ_P   (N),
        .NUM_CDB_P   (C),
        .WORD_SIZE_P (16)
    ) dut (
        .clk_i       (clk),
        .reset_n_i   (rst_n),
        .flush_i     (flush),
        .fu_v_i      (fu_v),
        .fu_result_i (fu_res),
        .fu_ready_o  (fu_ready),
        .cdb_v_o     (cdb_v),
        .cdb_o       (cdb)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Oldest-pointer-first scan: the first C buffered FUs from m_ptr onward win.
    function automatic logic [N-1:0] model_grant();
        logic [N-1:0] g = '0;
        int           c = 0;
        for (int j = 0; j < N; j++) begin
            int idx;
            idx = (m_ptr + j) % N;
            if (m_hv[idx] && c < C) begin
                g[idx] = 1'b1;
                c++;
            end
        end
        return g;
    endfunction

    function automatic logic [N-1:0] model_ready();
        return flush ? '0 : (~m_hv | model_grant());
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_hv  = '0;
            m_cv  = '0;
            m_ptr = 0;
            for (int k = 0; k < C; k++) m_cd[k] = '0;
        end else begin
            m_cnt = 0;
            m_g   = '0;
            for (int j = 0; j < N; j++) begin
                m_idx = (m_ptr + j) % N;
                if (m_hv[m_idx] && m_cnt < C) begin
                    m_sl[m_cnt] = m_idx;
                    m_g[m_idx]  = 1'b1;
                    m_cnt++;
                end
            end
            m_rdy = flush ? '0 : (~m_hv | m_g);
            if (flush) begin
                m_hv = '0;
                m_cv = '0;
            end else begin
                for (int k = 0; k < C; k++) begin
                    m_cv[k] = (k < m_cnt);
                    if (k < m_cnt) m_cd[k] = m_hd[m_sl[k]];
                end
                m_hv = m_hv & ~m_g;
                for (int r = 0; r < N; r++) begin
                    if (fu_v[r] && m_rdy[r]) begin
                        m_hd[r] = fu_res[r];
                        m_hv[r] = 1'b1;
                    end
                end
                if (m_cnt > 0) m_ptr = (m_sl[m_cnt-1] + 1) % N;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("cyc_fu_ready", fu_ready, model_ready());
            check("cyc_cdb_v", cdb_v, m_cv);
            for (int k = 0; k < C; k++) begin
                if (m_cv[k]) check($sformatf("cyc_cdb_o%0d", k), cdb[k], m_cd[k]);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        acc = fu_v & fu_ready;
        @(posedge clk);
        #2;
    endtask

    // All four FUs valid for one cycle starting from rr_ptr = 0.
    task automatic burst(input logic [15:0] base, input string tag);
        for (int r = 0; r < N; r++) fu_res[r] = CDB_t'{dest: 5'(8 + r), data: base + 16'(r)};
        fu_v = 4'hF;
        tick();
        fu_v = '0;
        #1 check({tag, "_t1_v"}, cdb_v, 2'b00);
        tick();
        #1 check({tag, "_t2_v"}, cdb_v, 2'b11);
        check({tag, "_t2_s0"}, cdb[0], CDB_t'{dest: 5'd8, data: base});
        check({tag, "_t2_s1"}, cdb[1], CDB_t'{dest: 5'd9, data: base + 16'd1});
        tick();
        #1 check({tag, "_t3_v"}, cdb_v, 2'b11);
        check({tag, "_t3_s0"}, cdb[0], CDB_t'{dest: 5'd10, data: base + 16'd2});
        check({tag, "_t3_s1"}, cdb[1], CDB_t'{dest: 5'd11, data: base + 16'd3});
        tick();
        #1 check({tag, "_t4_v"}, cdb_v, 2'b00);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        rst_n  = 1'b0;
        flush  = 1'b0;
        fu_v   = '0;
        fu_res = '0;
        acc    = '0;
        #12;
        check("rst_cdb_v", cdb_v, 2'b00);
        check("rst_cdb_o", cdb, '0);
        #10 rst_n = 1'b1;
        #1 check("rst_ready", fu_ready, 4'hF);
        @(posedge clk);
        #2;

        burst(16'hB000, "burst");

        // Single result from FU2; rr_ptr moves to 3
        fu_res[2] = CDB_t'{dest: 5'd5, data: 16'h1234};
        fu_v = 4'b0100;
        tick();
        fu_v = '0;
        #1 check("single_t1_v", cdb_v, 2'b00);
        tick();
        #1 check("single_t2_v", cdb_v, 2'b01);
        check("single_t2_s0", cdb[0], CDB_t'{dest: 5'd5, data: 16'h1234});
        tick();
        #1 check("single_t3_v", cdb_v, 2'b00);

        // Saturation: every FU valid every cycle, data advances only when accepted
        for (int r = 0; r < N; r++) begin
            seq[r]     = 0;
            sat_cnt[r] = 0;
            fu_res[r]  = CDB_t'{dest: 5'(r), data: 16'(r * 256)};
        end
        fu_v = 4'hF;
        for (int i = 0; i < 3; i++) begin
            tick();
            for (int r = 0; r < N; r++) if (acc[r]) begin
                seq[r]++;
                fu_res[r].data = 16'(r * 256 + seq[r]);
            end
        end
        #1 prev_rdy0 = fu_ready[0];
        toggles = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            for (int r = 0; r < N; r++) if (acc[r]) begin
                seq[r]++;
                fu_res[r].data = 16'(r * 256 + seq[r]);
            end
            #1;
            for (int k = 0; k < C; k++) if (cdb_v[k]) sat_cnt[cdb[k].dest % N]++;
            if (fu_ready[0] != prev_rdy0) toggles++;
            prev_rdy0 = fu_ready[0];
        end
        for (int r = 0; r < N; r++) check($sformatf("sat_grants_fu%0d", r), 64'(sat_cnt[r]), 64'd4);
        check("sat_ready_toggles", 64'(toggles), 64'd8);

        // Asynchronous reset in the middle of saturated traffic
        check("pre_rst_v", cdb_v, 2'b11);
        #3;
        rst_n = 1'b0;
        fu_v  = '0;
        #1 check("rst_mid_v", cdb_v, 2'b00);
        check("rst_mid_o", cdb, '0);
        check("rst_mid_ready", fu_ready, 4'hF);
        @(posedge clk);
        #2 rst_n = 1'b1;
        #1 check("rst_rel_ready", fu_ready, 4'hF);
        burst(16'hC000, "burst2");

        // Streaming from FU3 only
        stream_d  = 0;
        fu_res[3] = CDB_t'{dest: 5'd3, data: 16'h3000};
        fu_v      = 4'b1000;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (acc[3]) begin
                stream_d++;
                fu_res[3].data = 16'h3000 + 16'(stream_d);
            end
            #1 check("stream_ready3", fu_ready[3], 1'b1);
            if (i == 1) begin
                check("stream_first_v", cdb_v, 2'b01);
                check("stream_first_d", cdb[0].data, 16'h3000);
            end
            if (i == 2) check("stream_second_d", cdb[0].data, 16'h3001);
        end
        fu_v = '0;
        tick();
        tick();

        // Flush with FU0, FU1, FU3 buffered
        fu_res[0] = CDB_t'{dest: 5'd1, data: 16'hF000};
        fu_res[1] = CDB_t'{dest: 5'd2, data: 16'hF001};
        fu_res[3] = CDB_t'{dest: 5'd4, data: 16'hF003};
        fu_v = 4'b1011;
        tick();
        fu_v  = '0;
        flush = 1'b1;
        #1 check("flush_ready", fu_ready, 4'h0);
        tick();
        flush = 1'b0;
        #1 check("flush_cdb_v", cdb_v, 2'b00);
        check("flush_hold_clear", fu_ready, 4'hF);
        for (int i = 0; i < 3; i++) begin
            tick();
            #1 check("flush_quiet", cdb_v, 2'b00);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
